// File: rtl/rtc_set_ctrl_pkg.sv
// Shared state encoding, BCD field limits and field-select codes for the RTC time-set controller.
package rtc_set_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_SET_SEC = 3'd3,
        ST_COMMIT  = 3'd4
    } state_t;

    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    localparam logic [1:0] FSEL_NONE = 2'b00;
    localparam logic [1:0] FSEL_HR   = 2'b01;
    localparam logic [1:0] FSEL_MIN  = 2'b10;
    localparam logic [1:0] FSEL_SEC  = 2'b11;

    function automatic logic is_set(state_t s);
        return (s == ST_SET_HR) || (s == ST_SET_MIN) || (s == ST_SET_SEC);
    endfunction

    function automatic logic [1:0] field_of(state_t s);
        case (s)
            ST_SET_HR:  return FSEL_HR;
            ST_SET_MIN: return FSEL_MIN;
            ST_SET_SEC: return FSEL_SEC;
            default:    return FSEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_set_ctrl_bcd2_inc.sv
// Two-digit BCD increment with wrap at max; anything not a valid BCD value <= max becomes 00.
module bcd2_inc (
    input  logic [7:0] val,
    input  logic [7:0] max,
    output logic [7:0] res
);

    logic valid;

    always_comb begin
        // Plain numeric compare is safe once both digits are known to be 0..9.
        valid = (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max);
        res   = 8'h00;
        if (valid && (val != max)) begin
            if (val[3:0] == 4'd9)
                res = {val[7:4] + 4'd1, 4'd0};
            else
                res = {val[7:4], val[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/rtc_set_ctrl.sv
// Time-set controller: gates the RTC count enable, sequences hr/min/sec editing from two
// buttons and commits the edited time with a single load pulse.
module rtc_set_ctrl
    import rtc_set_ctrl_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 30,
    parameter int TO_W          = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hr,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       run_en,
    output logic       load,
    output logic [7:0] ld_hr,
    output logic [7:0] ld_min,
    output logic [7:0] ld_sec,
    output logic [1:0] field_sel,
    output logic       blink
);

    state_t          state, state_nxt;
    logic            mode_q, inc_q;
    logic            mode_e, inc_e;
    logic [TO_W-1:0] to_cnt;
    logic            timeout;
    logic            set_nxt, stay;
    logic [1:0]      field_nxt;
    logic [7:0]      edit_hr, edit_min, edit_sec;
    logic [7:0]      inc_in, inc_max, inc_res;

    assign mode_e  = btn_mode & ~mode_q;
    assign inc_e   = btn_inc & ~inc_q;
    // A button edge restarts the idle window, so it always beats an expiring tick.
    assign timeout = tick && (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) && !mode_e && !inc_e;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:     if (mode_e) state_nxt = ST_SET_HR;
            ST_SET_HR:  if (mode_e) state_nxt = ST_SET_MIN;
                        else if (timeout) state_nxt = ST_RUN;
            ST_SET_MIN: if (mode_e) state_nxt = ST_SET_SEC;
                        else if (timeout) state_nxt = ST_RUN;
            ST_SET_SEC: if (mode_e) state_nxt = ST_COMMIT;
                        else if (timeout) state_nxt = ST_RUN;
            ST_COMMIT:  state_nxt = ST_RUN;
            default:    state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        run_en    = (state == ST_RUN) && tick;
        set_nxt   = is_set(state_nxt);
        stay      = set_nxt && (state_nxt == state);
        field_nxt = field_of(state_nxt);
        case (state)
            ST_SET_MIN: begin inc_in = edit_min; inc_max = MS_MAX; end
            ST_SET_SEC: begin inc_in = edit_sec; inc_max = MS_MAX; end
            default:    begin inc_in = edit_hr;  inc_max = HR_MAX; end
        endcase
    end

    bcd2_inc u_inc (
        .val (inc_in),
        .max (inc_max),
        .res (inc_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // History starts high so a button held through reset produces no edge.
            mode_q    <= 1'b1;
            inc_q     <= 1'b1;
            to_cnt    <= '0;
            edit_hr   <= 8'h00;
            edit_min  <= 8'h00;
            edit_sec  <= 8'h00;
            load      <= 1'b0;
            ld_hr     <= 8'h00;
            ld_min    <= 8'h00;
            ld_sec    <= 8'h00;
            field_sel <= FSEL_NONE;
            blink     <= 1'b0;
        end else begin
            mode_q    <= btn_mode;
            inc_q     <= btn_inc;
            field_sel <= field_nxt;
            load      <= (state_nxt == ST_COMMIT);

            if (state_nxt == ST_COMMIT) begin
                ld_hr  <= edit_hr;
                ld_min <= edit_min;
                ld_sec <= edit_sec;
            end

            if (state == ST_RUN && mode_e) begin
                edit_hr  <= cur_hr;
                edit_min <= cur_min;
                edit_sec <= cur_sec;
            end else if (inc_e && !mode_e) begin
                case (state)
                    ST_SET_HR:  edit_hr  <= inc_res;
                    ST_SET_MIN: edit_min <= inc_res;
                    ST_SET_SEC: edit_sec <= inc_res;
                    default:    ;
                endcase
            end

            if (!stay || mode_e || inc_e)
                to_cnt <= '0;
            else if (tick)
                to_cnt <= to_cnt + TO_W'(1);

            if (!stay)
                blink <= 1'b0;
            else if (tick)
                blink <= ~blink;
        end
    end

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Scoreboard bench for rtc_set_ctrl: a behavioural model predicts commits into a queue,
// a negedge monitor pops on every load pulse and also tracks the per-cycle outputs.
module tb_rtc_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [7:0] cur_hr = 8'h00, cur_min = 8'h00, cur_sec = 8'h00;
    logic       run_en, load, blink;
    logic [7:0] ld_hr, ld_min, ld_sec;
    logic [1:0] field_sel;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];

    // model: st 0=run 1=hr 2=min 3=sec 4=commit
    int         st = 0;
    int         m_to = 0;
    bit         m_blink = 0, m_mq = 1, m_iq = 1;
    logic [7:0] mv [1:3];
    logic [7:0] mld[1:3];

    rtc_set_ctrl #(.TIMEOUT_TICKS(30), .TO_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .cur_hr    (cur_hr),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .run_en    (run_en),
        .load      (load),
        .ld_hr     (ld_hr),
        .ld_min    (ld_min),
        .ld_sec    (ld_sec),
        .field_sel (field_sel),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_inc(input logic [7:0] v, input int max);
        int t, u, n;
        t = int'(v[7:4]);
        u = int'(v[3:0]);
        if (t > 9 || u > 9) return 8'h00;
        n = t * 10 + u;
        if (n >= max) return 8'h00;
        n = n + 1;
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    function automatic logic [1:0] m_fsel(input int s);
        return (s >= 1 && s <= 3) ? 2'(s) : 2'b00;
    endfunction

    // Reference model, evaluated at each active edge from the inputs held over the past cycle.
    initial begin
        for (int i = 1; i <= 3; i++) begin mv[i] = 8'h00; mld[i] = 8'h00; end
        forever begin
            bit me, ie;
            @(posedge clk);
            me = btn_mode && !m_mq;
            ie = btn_inc && !m_iq;
            m_mq = btn_mode;
            m_iq = btn_inc;
            if (rst) begin
                st = 0; m_to = 0; m_blink = 0; m_mq = 1; m_iq = 1;
                for (int i = 1; i <= 3; i++) begin mv[i] = 8'h00; mld[i] = 8'h00; end
            end else if (st == 0) begin
                if (me) begin
                    st = 1; m_to = 0; m_blink = 0;
                    mv[1] = cur_hr; mv[2] = cur_min; mv[3] = cur_sec;
                end
            end else if (st == 4) begin
                st = 0;
            end else begin
                if (me) begin
                    st = st + 1; m_to = 0; m_blink = 0;
                    if (st == 4) begin
                        for (int i = 1; i <= 3; i++) mld[i] = mv[i];
                        exp_q.push_back({mv[1], mv[2], mv[3]});
                    end
                end else if (ie) begin
                    mv[st] = m_inc(mv[st], (st == 1) ? 23 : 59);
                    m_to = 0;
                    if (tick) m_blink = !m_blink;
                end else if (tick) begin
                    m_to = m_to + 1;
                    if (m_to == 30) begin st = 0; m_to = 0; m_blink = 0; end
                    else m_blink = !m_blink;
                end
            end
        end
    end

    // Monitor: load pulses are matched against queued commits; other outputs each cycle.
    initial begin
        forever begin
            @(negedge clk);
            chk("run_en", run_en, 32'(st == 0 && tick));
            chk("field_sel", field_sel, m_fsel(st));
            chk("blink", blink, m_blink);
            chk("load", load, 32'(st == 4));
            chk("ld_hold", {ld_hr, ld_min, ld_sec}, {mld[1], mld[2], mld[3]});
            if (load) begin
                if (exp_q.size() == 0) begin
                    chk("load_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    chk("load_value", {ld_hr, ld_min, ld_sec}, e);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic pmode(); btn_mode = 1; step(); btn_mode = 0; step(); endtask
    task automatic pinc();  btn_inc = 1;  step(); btn_inc = 0;  step(); endtask
    task automatic ptick(); tick = 1;     step(); tick = 0;     step(); endtask

    initial begin
        rst = 1; step(3); rst = 0; step();
        chk("rst_field", field_sel, 2'b00);
        chk("rst_load", load, 1'b0);
        chk("rst_ld", {ld_hr, ld_min, ld_sec}, 24'h000000);
        chk("rst_blink", blink, 1'b0);

        // run mode: enable follows tick
        repeat (5) ptick();
        tick = 1; #1;
        chk("t1_run_en", run_en, 1'b1);
        step(); tick = 0; step();

        // full edit 12:34:56 -> 15:00:00
        cur_hr = 8'h12; cur_min = 8'h34; cur_sec = 8'h56;
        pmode();
        repeat (3) pinc();
        pmode();
        repeat (26) pinc();
        pmode();
        repeat (4) pinc();
        pmode();
        step(2);
        chk("t2_ld", {ld_hr, ld_min, ld_sec}, 24'h150000);

        // wrap and invalid values
        cur_hr = 8'h23; cur_min = 8'h59; cur_sec = 8'h3A;
        pmode(); pinc(); pmode(); pinc(); pmode(); pinc(); pmode();
        step(2);
        chk("t3_wrap", {ld_hr, ld_min, ld_sec}, 24'h000000);
        cur_hr = 8'h24; cur_min = 8'h1A; cur_sec = 8'h09;
        pmode(); pinc(); pmode(); pinc(); pmode(); pinc(); pmode();
        step(2);
        chk("t3_invalid_carry", {ld_hr, ld_min, ld_sec}, 24'h000010);

        // timeout in SET_MIN
        cur_hr = 8'h01; cur_min = 8'h02; cur_sec = 8'h03;
        pmode(); pmode();
        repeat (29) ptick();
        chk("t4_still_set", field_sel, 2'b10);
        ptick();
        chk("t4_to_run", field_sel, 2'b00);
        step(2);
        chk("t4_ld_kept", {ld_hr, ld_min, ld_sec}, 24'h000010);

        // simultaneous mode and inc edges
        pmode();
        btn_mode = 1; btn_inc = 1; step();
        chk("t5_adv", field_sel, 2'b10);
        btn_mode = 0; btn_inc = 0; step();
        pmode(); pmode();
        step(2);
        chk("t5_hr_kept", {ld_hr, ld_min, ld_sec}, 24'h010203);

        // mode held through reset, then reset with commit pending
        btn_mode = 1; rst = 1; step(2); rst = 0; step(3);
        chk("t6_held", field_sel, 2'b00);
        btn_mode = 0; step();
        pmode(); pmode(); pmode();
        chk("t6_in_sec", field_sel, 2'b11);
        btn_mode = 1; rst = 1; step();
        chk("t6_no_load", load, 1'b0);
        chk("t6_run", field_sel, 2'b00);
        rst = 0; btn_mode = 0; step(3);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 2) == 0)  btn_inc  = ~btn_inc;
            if ($urandom_range(0, 49) == 0) begin
                cur_hr  = 8'($urandom);
                cur_min = 8'($urandom);
                cur_sec = 8'($urandom);
            end
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 0; tick = 0; btn_mode = 0; btn_inc = 0;
        step(4);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
